// File: rtl/multicycle_control.sv
// Main sequencer for the multicycle RISC-V core: one state register, with
// datapath selects and strobes decoded combinationally from the current state.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_update,
  output logic       branch,
  output logic       reg_write,
  output logic       mem_write,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXECR, S_EXECI, S_JAL, S_ALUWB, S_BEQ, S_ERROR
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ERROR;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_ERROR;
    endcase
  end

  always_comb begin
    alu_op     = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        // Reset forces FETCH, but no fetch may be committed while held in reset.
        ir_write   = mem_ready & rst_n;
        pc_update  = mem_ready & rst_n;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_ERROR:    illegal = 1'b1;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, hand sequences for
// stalls/traps/async reset, and a randomized run against a step-queue model.
module tb_multicycle_control;
  logic       clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [6:0] op = 7'd0;
  logic [1:0] alu_op, alu_src_a, alu_src_b, result_src;
  logic       adr_src, ir_write, pc_update, branch, reg_write, mem_write, instr_done, illegal;
  logic [15:0] act;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .adr_src(adr_src), .ir_write(ir_write),
    .pc_update(pc_update), .branch(branch), .reg_write(reg_write),
    .mem_write(mem_write), .instr_done(instr_done), .illegal(illegal)
  );

  assign act = {alu_op, alu_src_a, alu_src_b, result_src, adr_src, ir_write,
                pc_update, branch, reg_write, mem_write, instr_done, illegal};

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  // Expected output words {alu_op,src_a,src_b,result_src,adr,ir,pc,br,rw,mw,done,ill}
  localparam logic [15:0] E_F1 = 16'h0A60, E_F0 = 16'h0A00, E_D = 16'h1400;
  localparam logic [15:0] E_MA = 16'h2400, E_MR = 16'h0080, E_WB = 16'h010A;
  localparam logic [15:0] E_MW1 = 16'h0086, E_MW0 = 16'h0084, E_ER = 16'hA000;
  localparam logic [15:0] E_EI = 16'hA400, E_J = 16'h1820, E_AW = 16'h000A;
  localparam logic [15:0] E_B = 16'h6012, E_ERR = 16'h0001;

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // Entered at a negedge: drive, check comb outputs, wait for the next negedge.
  task automatic step(input logic [6:0] o, input logic mr, input logic [15:0] e, input string nm);
    op = o; mem_ready = mr;
    #1 chk(nm, act, e);
    @(negedge clk);
  endtask

  typedef struct { logic [6:0] op; logic mr; logic [15:0] exp; } vec_t;
  vec_t tbl[22];

  // Model: an instruction is a list of steps; stalls repeat FETCH/MEMREAD/MEMWRITE.
  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MW = 4, P_WB = 5;
  localparam int P_ER = 6, P_EI = 7, P_J = 8, P_AW = 9, P_B = 10;

  function automatic logic [15:0] exp_of(input int s, input logic mr);
    case (s)
      P_F:  return mr ? E_F1 : E_F0;
      P_D:  return E_D;
      P_MA: return E_MA;
      P_MR: return E_MR;
      P_MW: return mr ? E_MW1 : E_MW0;
      P_WB: return E_WB;
      P_ER: return E_ER;
      P_EI: return E_EI;
      P_J:  return E_J;
      P_AW: return E_AW;
      default: return E_B;
    endcase
  endfunction

  initial begin
    int q[$];
    logic [6:0] legal [6];
    logic [6:0] cur;
    logic [6:0] o;
    logic mr;
    int s, n;

    tbl = '{
      '{7'h00, 1'b1, E_F1}, '{LW, 1'b1, E_D}, '{LW, 1'b1, E_MA}, '{7'h7F, 1'b1, E_MR},
      '{7'h00, 1'b1, E_WB},
      '{7'h00, 1'b1, E_F1}, '{BQ, 1'b1, E_D}, '{7'h55, 1'b1, E_B},
      '{7'h00, 1'b1, E_F1}, '{RT, 1'b1, E_D}, '{7'h00, 1'b1, E_ER}, '{7'h00, 1'b1, E_AW},
      '{7'h00, 1'b1, E_F1}, '{IT, 1'b1, E_D}, '{7'h00, 1'b1, E_EI}, '{7'h00, 1'b1, E_AW},
      '{7'h00, 1'b1, E_F1}, '{JL, 1'b1, E_D}, '{7'h00, 1'b1, E_J},  '{7'h00, 1'b1, E_AW},
      '{7'h00, 1'b0, E_F0}, '{7'h00, 1'b1, E_F1}
    };
    legal = '{LW, SW, RT, IT, BQ, JL};

    // Reset: FETCH selects visible, strobes gated off even with mem_ready high.
    @(negedge clk);
    mem_ready = 1'b1;
    #1 chk("reset_state", act, E_F0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) step(tbl[i].op, tbl[i].mr, tbl[i].exp, $sformatf("tbl[%0d]", i));
    // tbl ended by fetching; finish that instruction as a beq to resync.
    step(BQ, 1'b1, E_D, "tbl_tail_dec");
    step(7'h00, 1'b1, E_B, "tbl_tail_beq");

    // sw with three stall cycles in MEMWRITE: 7 cycles, mem_write held 4.
    step(7'h00, 1'b1, E_F1, "sw_fetch");
    step(SW, 1'b1, E_D, "sw_dec");
    step(SW, 1'b1, E_MA, "sw_memadr");
    for (int i = 0; i < 3; i++) step(7'h13, 1'b0, E_MW0, "sw_stall");
    step(7'h00, 1'b1, E_MW1, "sw_done");

    // Randomized run against the step-queue model.
    n = 0; cur = LW;
    while (1) begin
      if (q.size() == 0) begin
        if (n >= 300) break;
        cur = legal[$urandom_range(0, 5)];
        q.push_back(P_F); q.push_back(P_D);
        case (cur)
          LW: begin q.push_back(P_MA); q.push_back(P_MR); q.push_back(P_WB); end
          SW: begin q.push_back(P_MA); q.push_back(P_MW); end
          RT: begin q.push_back(P_ER); q.push_back(P_AW); end
          IT: begin q.push_back(P_EI); q.push_back(P_AW); end
          JL: begin q.push_back(P_J);  q.push_back(P_AW); end
          default: q.push_back(P_B);
        endcase
      end
      s = q[0];
      mr = ($urandom_range(0, 3) != 0);
      o = (s == P_D || s == P_MA) ? cur : 7'($urandom);
      step(o, mr, exp_of(s, mr), "rand");
      if (!((s == P_F || s == P_MR || s == P_MW) && !mr)) void'(q.pop_front());
      n++;
    end

    // Async reset mid-MEMWRITE: mem_write must drop before the next edge.
    step(7'h00, 1'b1, E_F1, "rst_fetch");
    step(SW, 1'b1, E_D, "rst_dec");
    step(SW, 1'b1, E_MA, "rst_memadr");
    mem_ready = 1'b0;
    #1 chk("rst_in_memwrite", act, E_MW0);
    #1 rst_n = 1'b0; mem_ready = 1'b1;
    #1 chk("async_reset", act, E_F0);
    @(negedge clk);
    rst_n = 1'b1;
    step(7'h00, 1'b0, E_F0, "post_reset_fetch");

    // Illegal opcode traps until reset.
    step(7'h00, 1'b1, E_F1, "ill_fetch");
    step(7'h00, 1'b1, E_D, "ill_dec");
    for (int i = 0; i < 22; i++) step(7'($urandom), 1'($urandom), E_ERR, "illegal_hold");
    rst_n = 1'b0;
    #1 chk("ill_reset", act, E_F0);
    @(negedge clk);
    rst_n = 1'b1;
    step(7'h00, 1'b1, E_F1, "ill_recover");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
